// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: two AXI4-Stream sources share one registered
// output. A grant is held from the first beat to the tlast beat, so packets never
// interleave. Per-source completed-packet counters are exposed for debug.
module axis_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic                  grant_id,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

    typedef enum logic [0:0] {StIdle, StPkt} state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e                 state_q;
    logic                   last_q;
    logic                   grant_q;
    logic                   tvalid_q;
    logic                   tlast_q;
    logic [DATA_WIDTH-1:0]  tdata_q;
    logic [CNT_WIDTH-1:0]   cnt0_q;
    logic [CNT_WIDTH-1:0]   cnt1_q;

    logic                   out_free;
    logic                   in_ready;
    logic                   in_valid;
    logic                   in_fire;
    logic                   in_last;
    logic [DATA_WIDTH-1:0]  in_data;

    // Ready path: combinational from m_axis_tready to the granted source only.
    always_comb begin
        out_free       = !tvalid_q || m_axis_tready;
        in_ready       = (state_q == StPkt) && out_free;
        s0_axis_tready = in_ready && !grant_q;
        s1_axis_tready = in_ready && grant_q;
        in_valid       = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
        in_last        = grant_q ? s1_axis_tlast  : s0_axis_tlast;
        in_data        = grant_q ? s1_axis_tdata  : s0_axis_tdata;
        in_fire        = in_valid && in_ready;
    end

    // Arbitration FSM, packet counters and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        // On a tie, serve whichever source did not go last.
                        grant_q <= (s0_axis_tvalid && s1_axis_tvalid) ? !last_q
                                                                       : s1_axis_tvalid;
                        state_q <= StPkt;
                    end
                end
                StPkt: begin
                    if (in_fire && in_last) begin
                        state_q <= StIdle;
                        last_q  <= grant_q;
                        if (grant_q) begin
                            cnt1_q <= cnt1_q + CntOne;
                        end else begin
                            cnt0_q <= cnt0_q + CntOne;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A new beat replaces the register even during an output handshake.
            if (in_fire) begin
                tvalid_q <= 1'b1;
                tdata_q  <= in_data;
                tlast_q  <= in_last;
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    // Status and stream outputs come straight from registers.
    always_comb begin
        m_axis_tdata  = tdata_q;
        m_axis_tvalid = tvalid_q;
        m_axis_tlast  = tlast_q;
        grant_id      = grant_q;
        busy          = (state_q == StPkt) || tvalid_q;
        pkt_cnt0      = cnt0_q;
        pkt_cnt1      = cnt1_q;
    end

endmodule
